// File: rtl/mem_sweep_pkg.sv
// Shared types and helpers for the BRAM sweep controller.
package mem_sweep_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_SCAN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  localparam logic MODE_SCAN = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  // Reference word for an address. Computed at 32 bits; callers truncate to
  // the memory width, which equals "truncate the address, then XOR the seed".
  function automatic logic [31:0] pattern(input logic [31:0] addr,
                                          input logic [31:0] seed);
    return addr ^ seed;
  endfunction

endpackage

// File: rtl/mem_sweep_acc.sv
// Result accumulator for SCAN: running checksum, saturating mismatch count
// and the address of the first mismatching word.
module mem_sweep_acc
  import mem_sweep_pkg::*;
#(
  parameter int WID_MEM = 8,
  parameter int CNT_W   = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear_i,
  input  logic               valid_i,
  input  logic [31:0]        addr_i,
  input  logic [WID_MEM-1:0] data_i,
  input  logic [WID_MEM-1:0] expected_i,
  output logic [31:0]        checksum_o,
  output logic [CNT_W-1:0]   err_count_o,
  output logic [31:0]        first_err_addr_o
);

  logic [31:0]      checksum_q;
  logic [CNT_W-1:0] err_count_q;
  logic [31:0]      first_err_addr_q;

  // Accumulate one consumed word per valid cycle; clear restarts the results.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (reset || clear_i) begin
      checksum_q       <= '0;
      err_count_q      <= '0;
      first_err_addr_q <= '1;
    end else if (valid_i) begin
      checksum_q <= checksum_q + 32'(data_i);
      if (data_i != expected_i) begin
        if (err_count_q != '1) err_count_q <= err_count_q + CNT_W'(1);
        // The counter never wraps back to zero, so zero marks "no mismatch yet".
        if (err_count_q == '0) first_err_addr_q <= addr_i;
      end
    end
  end

  assign checksum_o       = checksum_q;
  assign err_count_o      = err_count_q;
  assign first_err_addr_o = first_err_addr_q;

endmodule

// File: rtl/mem_sweep_ctrl.sv
// BRAM sweep controller: FILL writes pattern(addr) to every scan address,
// SCAN reads every scan address, writes it back unchanged and reports results.
module mem_sweep_ctrl
  import mem_sweep_pkg::*;
#(
  parameter int WID_MEM   = 8,
  parameter int DEPTH_MEM = 2048,
  parameter int PARK_ADDR = DEPTH_MEM - 1,
  parameter int CNT_W     = $clog2(DEPTH_MEM) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               mode,
  input  logic [WID_MEM-1:0] seed,
  output logic [31:0]        mem_raddr,
  output logic [31:0]        mem_waddr,
  output logic [WID_MEM-1:0] mem_din,
  input  logic [WID_MEM-1:0] mem_dout,
  output logic               busy,
  output logic               done,
  output logic [31:0]        checksum,
  output logic [CNT_W-1:0]   err_count,
  output logic [31:0]        first_err_addr
);

  localparam logic [31:0] LAST = 32'(DEPTH_MEM - 1);  // N: number of scanned words
  localparam logic [31:0] PARK = 32'(PARK_ADDR);

  state_e             state_q, state_d;
  logic [WID_MEM-1:0] seed_q, seed_d;
  logic [31:0]        cnt_q, cnt_d;
  logic [31:0]        raddr_q, raddr_d;
  logic [31:0]        waddr_q, waddr_d;
  logic [WID_MEM-1:0] din_q, din_d;
  logic               rd_pend_q, rd_pend_d;  // a read was issued this cycle
  logic               wb_q, wb_d;            // mem_dout holds the word at waddr_q
  logic               acc_clear;

  // Next-state and next-port logic for the sweep sequencer.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would infer a latch.
    state_d   = state_q;
    seed_d    = seed_q;
    cnt_d     = cnt_q;
    raddr_d   = PARK;
    rd_pend_d = 1'b0;
    wb_d      = rd_pend_q;
    waddr_d   = rd_pend_q ? raddr_q : PARK;  // write-back trails the read by one cycle
    din_d     = '0;
    acc_clear = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          seed_d    = seed;
          cnt_d     = 32'd1;
          acc_clear = 1'b1;
          if (mode == MODE_FILL) begin
            state_d = ST_FILL;
            waddr_d = 32'd0;
            din_d   = WID_MEM'(pattern(32'd0, 32'(seed)));
          end else begin
            state_d   = ST_SCAN;
            raddr_d   = 32'd0;
            rd_pend_d = 1'b1;
          end
        end
      end
      ST_FILL: begin
        if (cnt_q == LAST) begin
          state_d = ST_DONE;
        end else begin
          waddr_d = cnt_q;
          din_d   = WID_MEM'(pattern(cnt_q, 32'(seed_q)));
          cnt_d   = cnt_q + 32'd1;
        end
      end
      ST_SCAN: begin
        if (cnt_q == LAST) begin
          state_d = ST_DRAIN;
        end else begin
          raddr_d   = cnt_q;
          rd_pend_d = 1'b1;
          cnt_d     = cnt_q + 32'd1;
        end
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Sequencer registers; reset parks the memory ports on the scratch word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      seed_q    <= '0;
      cnt_q     <= '0;
      raddr_q   <= PARK;
      waddr_q   <= PARK;
      din_q     <= '0;
      rd_pend_q <= 1'b0;
      wb_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      seed_q    <= seed_d;
      cnt_q     <= cnt_d;
      raddr_q   <= raddr_d;
      waddr_q   <= waddr_d;
      din_q     <= din_d;
      rd_pend_q <= rd_pend_d;
      wb_q      <= wb_d;
    end
  end

  // Write-back passes the read word straight through so the rewrite is exact.
  assign mem_din   = wb_q ? mem_dout : din_q;
  assign mem_raddr = raddr_q;
  assign mem_waddr = waddr_q;
  assign busy      = (state_q == ST_FILL) || (state_q == ST_SCAN) || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);

  mem_sweep_acc #(
    .WID_MEM (WID_MEM),
    .CNT_W   (CNT_W)
  ) u_acc (
    .clk              (clk),
    .reset            (reset),
    .clear_i          (acc_clear),
    .valid_i          (wb_q),
    .addr_i           (waddr_q),
    .data_i           (mem_dout),
    .expected_i       (WID_MEM'(pattern(waddr_q, 32'(seed_q)))),
    .checksum_o       (checksum),
    .err_count_o      (err_count),
    .first_err_addr_o (first_err_addr)
  );

endmodule
